// File: rtl/framebox_ctrl_if.sv
// Bus bundle for framebox_ctrl: raster coordinates and host config in, mask and frame status out.
// The DUT uses the slave modport; the host/video side uses master.
interface framebox_ctrl_if;
  logic [10:0] gr_x;
  logic [9:0]  gr_y;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [10:0] cfg_data;
  logic        cfg_commit;
  logic        cfg_busy;
  logic        cfg_err;
  logic        outbl;
  logic        frame_start;
  logic [15:0] frame_cnt;

  modport master (
    output gr_x, gr_y, cfg_wr, cfg_addr, cfg_data, cfg_commit,
    input  cfg_busy, cfg_err, outbl, frame_start, frame_cnt
  );

  modport slave (
    input  gr_x, gr_y, cfg_wr, cfg_addr, cfg_data, cfg_commit,
    output cfg_busy, cfg_err, outbl, frame_start, frame_cnt
  );
endinterface

// File: rtl/framebox_ctrl.sv
// Frame blanking mask generator with host-writable shadow limits.
// Shadow limits are committed to the active set only on a frame boundary, so a frame never tears.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | shadow writable; a commit arms the controller
// ST_ARMED | commit pending; counts down hold, applies shadow on boundary
module framebox_ctrl #(
  parameter logic [10:0] X1_DEF      = 11'd0,
  parameter logic [10:0] X2_DEF      = 11'd720,
  parameter logic [9:0]  Y1_DEF      = 10'd0,
  parameter logic [9:0]  Y2_DEF      = 10'd100,
  parameter logic [9:0]  Y3_DEF      = 10'd390,
  parameter logic [9:0]  Y4_DEF      = 10'd480,
  parameter int unsigned HOLD_FRAMES = 0
) (
  input logic            clk,
  input logic            reset,
  framebox_ctrl_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  logic [0:0]  state;
  logic [3:0]  hold;

  logic [10:0] sh_x1, sh_x2;
  logic [9:0]  sh_y1, sh_y2, sh_y3, sh_y4;
  logic [10:0] act_x1, act_x2;
  logic [9:0]  act_y1, act_y2, act_y3, act_y4;

  logic        origin, prev_origin, fb;
  logic        addr_is_y, wr_ok, wr_bad, commit_bad, apply;
  logic [10:0] l_x1, l_x2;
  logic [9:0]  l_y1, l_y2, l_y3, l_y4;
  logic        in_x, band_a, band_b;

  logic        outbl_q, frame_start_q, busy_q, err_q;
  logic [15:0] frame_cnt_q;

  assign origin = (bus.gr_x == 11'd0) && (bus.gr_y == 10'd0);
  assign fb     = origin && !prev_origin;

  assign addr_is_y  = (bus.cfg_addr >= 3'd2) && (bus.cfg_addr <= 3'd5);
  assign wr_ok      = bus.cfg_wr && (state == ST_IDLE) && (bus.cfg_addr <= 3'd5)
                      && !(addr_is_y && bus.cfg_data[10]);
  assign wr_bad     = bus.cfg_wr && !wr_ok;
  assign commit_bad = bus.cfg_commit && (state == ST_ARMED);
  assign apply      = (state == ST_ARMED) && fb && (hold == 4'd0);

  // On the applying boundary the pixel already sees the shadow set, so the whole new frame is consistent.
  assign l_x1 = apply ? sh_x1 : act_x1;
  assign l_x2 = apply ? sh_x2 : act_x2;
  assign l_y1 = apply ? sh_y1 : act_y1;
  assign l_y2 = apply ? sh_y2 : act_y2;
  assign l_y3 = apply ? sh_y3 : act_y3;
  assign l_y4 = apply ? sh_y4 : act_y4;

  assign in_x   = (bus.gr_x >= l_x1) && (bus.gr_x <= l_x2);
  assign band_a = in_x && (bus.gr_y >= l_y1) && (bus.gr_y <= l_y2);
  assign band_b = in_x && (bus.gr_y >= l_y3) && (bus.gr_y <= l_y4);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      hold          <= 4'd0;
      prev_origin   <= 1'b0;
      outbl_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 16'd0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      sh_x1  <= X1_DEF;  sh_x2  <= X2_DEF;
      sh_y1  <= Y1_DEF;  sh_y2  <= Y2_DEF;
      sh_y3  <= Y3_DEF;  sh_y4  <= Y4_DEF;
      act_x1 <= X1_DEF;  act_x2 <= X2_DEF;
      act_y1 <= Y1_DEF;  act_y2 <= Y2_DEF;
      act_y3 <= Y3_DEF;  act_y4 <= Y4_DEF;
    end else begin
      prev_origin   <= origin;
      frame_start_q <= fb;
      outbl_q       <= band_a || band_b;
      err_q         <= wr_bad || commit_bad;
      if (fb) frame_cnt_q <= frame_cnt_q + 16'd1;

      if (wr_ok) begin
        case (bus.cfg_addr)
          3'd0:    sh_x1 <= bus.cfg_data;
          3'd1:    sh_x2 <= bus.cfg_data;
          3'd2:    sh_y1 <= bus.cfg_data[9:0];
          3'd3:    sh_y2 <= bus.cfg_data[9:0];
          3'd4:    sh_y3 <= bus.cfg_data[9:0];
          3'd5:    sh_y4 <= bus.cfg_data[9:0];
          default: ;
        endcase
      end

      case (state)
        ST_IDLE: begin
          // A boundary coinciding with the commit is not counted; ARMED waits for the next one.
          if (bus.cfg_commit) begin
            state  <= ST_ARMED;
            hold   <= 4'(HOLD_FRAMES);
            busy_q <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (fb) begin
            if (hold != 4'd0) begin
              hold <= hold - 4'd1;
            end else begin
              act_x1 <= sh_x1;  act_x2 <= sh_x2;
              act_y1 <= sh_y1;  act_y2 <= sh_y2;
              act_y3 <= sh_y3;  act_y4 <= sh_y4;
              busy_q <= 1'b0;
              state  <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.outbl       = outbl_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.cfg_busy    = busy_q;
  assign bus.cfg_err     = err_q;

endmodule

// File: tb/tb_framebox_ctrl.sv
// Directed bench for framebox_ctrl: sparse raster sweeps, shadow commit timing, hold frames, errors, reset.
// Two instances share stimulus: dut0 with no hold frames, dut2 with two.
module tb_framebox_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] gx;
  logic [9:0]  gy;
  logic        wr, commit;
  logic [2:0]  addr;
  logic [10:0] data;

  int errors = 0;
  int checks = 0;
  bit use0 = 1'b1;
  bit use2 = 1'b0;
  int fc0 = 0;
  int fc2 = 0;

  // expected active limits: x1, x2, y1, y2, y3, y4
  int lim0 [6];
  int lim2 [6];

  int ys [19] = '{0, 1, 9, 10, 50, 51, 59, 60, 99, 100, 101, 200, 389, 390, 470, 471, 480, 481, 524};
  int xs [5]  = '{0, 4, 720, 721, 799};

  framebox_ctrl_if bus0 ();
  framebox_ctrl_if bus2 ();

  assign bus0.gr_x = gx;   assign bus2.gr_x = gx;
  assign bus0.gr_y = gy;   assign bus2.gr_y = gy;
  assign bus0.cfg_wr = wr;         assign bus2.cfg_wr = wr;
  assign bus0.cfg_addr = addr;     assign bus2.cfg_addr = addr;
  assign bus0.cfg_data = data;     assign bus2.cfg_data = data;
  assign bus0.cfg_commit = commit; assign bus2.cfg_commit = commit;

  framebox_ctrl dut0 (.clk(clk), .reset(rst_n), .bus(bus0));
  framebox_ctrl #(.HOLD_FRAMES(2)) dut2 (.clk(clk), .reset(rst_n), .bus(bus2));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_mask(int x, int y, int x1, int x2, int y1, int y2, int y3, int y4);
    bit ix;
    ix = (x >= x1) && (x <= x2);
    return (ix && y >= y1 && y <= y2) || (ix && y >= y3 && y <= y4);
  endfunction

  function automatic bit m0(int x, int y);
    return in_mask(x, y, lim0[0], lim0[1], lim0[2], lim0[3], lim0[4], lim0[5]);
  endfunction

  function automatic bit m2(int x, int y);
    return in_mask(x, y, lim2[0], lim2[1], lim2[2], lim2[3], lim2[4], lim2[5]);
  endfunction

  task automatic set_defaults();
    lim0 = '{0, 720, 0, 100, 390, 480};
    lim2 = '{0, 720, 0, 100, 390, 480};
    fc0 = 0;
    fc2 = 0;
  endtask

  task automatic px(input int x, input int y);
    gx = 11'(x);
    gy = 10'(y);
    tick();
    if (use0) chk($sformatf("outbl0 x=%0d y=%0d", x, y), 32'(bus0.outbl), 32'(m0(x, y)));
    if (use2) chk($sformatf("outbl2 x=%0d y=%0d", x, y), 32'(bus2.outbl), 32'(m2(x, y)));
  endtask

  // frame boundary: origin after a non-origin pixel
  task automatic bnd();
    fc0++;
    fc2++;
    px(0, 0);
    if (use0) begin
      chk("frame_start0", 32'(bus0.frame_start), 32'd1);
      chk("frame_cnt0", 32'(bus0.frame_cnt), 32'(fc0));
    end
    if (use2) chk("frame_cnt2", 32'(bus2.frame_cnt), 32'(fc2));
  endtask

  task automatic rows(input int ylo, input int yhi);
    for (int i = 0; i < 19; i++)
      if (ys[i] >= ylo && ys[i] <= yhi)
        for (int j = 0; j < 5; j++)
          if (!(xs[j] == 0 && ys[i] == 0)) px(xs[j], ys[i]);
  endtask

  task automatic wr_cfg(input logic [2:0] a, input logic [10:0] d, input bit exp_err);
    wr = 1'b1; addr = a; data = d;
    tick();
    wr = 1'b0;
    chk($sformatf("err_wr a=%0d", a), 32'(bus0.cfg_err), 32'(exp_err));
    tick();
    chk("err_clear", 32'(bus0.cfg_err), 32'd0);
  endtask

  task automatic do_commit(input bit exp_err);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("err_commit", 32'(bus0.cfg_err), 32'(exp_err));
    tick();
    chk("err_clear", 32'(bus0.cfg_err), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; commit = 1'b0; addr = 3'd0; data = 11'd0;
    gx = 11'd5; gy = 10'd5;
    set_defaults();
    tick(); tick();
    chk("rst_outbl", 32'(bus0.outbl), 32'd0);
    chk("rst_busy", 32'(bus0.cfg_busy), 32'd0);
    chk("rst_err", 32'(bus0.cfg_err), 32'd0);
    chk("rst_fs", 32'(bus0.frame_start), 32'd0);
    chk("rst_fcnt", 32'(bus0.frame_cnt), 32'd0);
    chk("rst_busy2", 32'(bus2.cfg_busy), 32'd0);
    rst_n = 1'b1;

    // default raster, static origin gives one boundary only
    use2 = 1'b1;
    bnd();
    px(0, 0);
    chk("static_fs", 32'(bus0.frame_start), 32'd0);
    chk("static_fcnt", 32'(bus0.frame_cnt), 32'd1);
    rows(0, 524);
    bnd();
    px(4, 0);
    chk("fs_drop", 32'(bus0.frame_start), 32'd0);
    rows(1, 524);
    use2 = 1'b0;

    // shadow write without commit is invisible
    gx = 11'd10; gy = 10'd300;
    wr_cfg(3'd3, 11'd50, 1'b0);
    chk("nocommit_busy", 32'(bus0.cfg_busy), 32'd0);
    bnd();
    rows(0, 524);
    chk("nocommit_busy2", 32'(bus0.cfg_busy), 32'd0);

    // commit mid-frame: rest of frame keeps old limits
    bnd();
    rows(0, 200);
    gx = 11'd10; gy = 10'd200;
    wr_cfg(3'd3, 11'd50, 1'b0);
    do_commit(1'b0);
    chk("mid_busy", 32'(bus0.cfg_busy), 32'd1);
    rows(201, 524);
    chk("mid_busy_end", 32'(bus0.cfg_busy), 32'd1);
    lim0[3] = 50;
    bnd();
    chk("mid_applied_busy", 32'(bus0.cfg_busy), 32'd0);
    rows(0, 524);

    // hold frames on dut2: apply on third boundary after commit
    rst_n = 1'b0; gx = 11'd5; gy = 10'd5;
    tick(); tick();
    rst_n = 1'b1;
    set_defaults();
    use2 = 1'b1;
    gx = 11'd10; gy = 10'd300;
    wr_cfg(3'd3, 11'd50, 1'b0);
    do_commit(1'b0);
    chk("hold_busy0", 32'(bus0.cfg_busy), 32'd1);
    chk("hold_busy2_a", 32'(bus2.cfg_busy), 32'd1);
    lim0[3] = 50;
    bnd();
    chk("hold_busy0_done", 32'(bus0.cfg_busy), 32'd0);
    chk("hold_busy2_b1", 32'(bus2.cfg_busy), 32'd1);
    rows(0, 524);
    bnd();
    chk("hold_busy2_b2", 32'(bus2.cfg_busy), 32'd1);
    rows(0, 524);
    chk("hold_busy2_b2_end", 32'(bus2.cfg_busy), 32'd1);
    lim2[3] = 50;
    bnd();
    chk("hold_busy2_b3", 32'(bus2.cfg_busy), 32'd0);
    rows(0, 524);
    use2 = 1'b0;

    // rejected writes and commits leave the limits unchanged
    gx = 11'd10; gy = 10'd300;
    wr_cfg(3'd6, 11'd5, 1'b1);
    wr_cfg(3'd4, 11'h400, 1'b1);
    do_commit(1'b0);
    chk("err_armed_busy", 32'(bus0.cfg_busy), 32'd1);
    wr_cfg(3'd0, 11'd5, 1'b1);
    do_commit(1'b1);
    chk("err_busy_kept", 32'(bus0.cfg_busy), 32'd1);
    bnd();
    chk("err_apply_busy", 32'(bus0.cfg_busy), 32'd0);
    rows(0, 524);

    // reset while armed discards the pending commit
    gx = 11'd10; gy = 10'd300;
    wr_cfg(3'd2, 11'd10, 1'b0);
    do_commit(1'b0);
    chk("rst_armed_busy", 32'(bus0.cfg_busy), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_busy", 32'(bus0.cfg_busy), 32'd0);
    chk("rst_mid_fcnt", 32'(bus0.frame_cnt), 32'd0);
    rst_n = 1'b1;
    set_defaults();
    bnd();
    chk("rst_noapply_busy", 32'(bus0.cfg_busy), 32'd0);
    rows(0, 524);

    // write and commit in one cycle: commit includes the write
    gx = 11'd10; gy = 10'd300;
    wr = 1'b1; addr = 3'd5; data = 11'd470; commit = 1'b1;
    tick();
    wr = 1'b0; commit = 1'b0;
    chk("wc_err", 32'(bus0.cfg_err), 32'd0);
    chk("wc_busy", 32'(bus0.cfg_busy), 32'd1);
    lim0[5] = 470;
    bnd();
    chk("wc_applied", 32'(bus0.cfg_busy), 32'd0);
    rows(0, 524);

    // commit on a boundary waits for the following boundary
    gx = 11'd10; gy = 10'd300;
    wr_cfg(3'd3, 11'd60, 1'b0);
    commit = 1'b1;
    fc0++;
    px(0, 0);
    commit = 1'b0;
    chk("cfb_fs", 32'(bus0.frame_start), 32'd1);
    chk("cfb_busy", 32'(bus0.cfg_busy), 32'd1);
    rows(0, 524);
    chk("cfb_busy_end", 32'(bus0.cfg_busy), 32'd1);
    lim0[3] = 60;
    bnd();
    chk("cfb_applied", 32'(bus0.cfg_busy), 32'd0);
    rows(0, 524);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
